mica_seq: RTL and testbench
===========================

// Module: mica_seq
// PURPOSE
//  Multi-cycle fetch/decode/execute sequencer for the Mica2 core; sits directly upstream of the 4->7 control decode ROM.
//  Fetches 8-bit instruction bytes, drives the ROM's opcode input from the instruction register, and registers the 7-bit control word.
//  Presents the registered control word to the datapath with a valid strobe; advances the PC on datapath completion or branch.
// PARAMETERS
//  PC_W     8      program-counter / memory address width
//  HALT_OP  4'hF   opcode that stops the sequencer after decode (no EXEC issued)
//  RESET_PC 0      PC value loaded on reset
// PORTS
//  clk            in   1     sole clock, rising edge
//  rst_n          in   1     reset, asynchronous, active-low
//  run            in   1     level; 1 = sequencer may fetch
//  resume         in   1     pulse; leaves HALT
//  mem_req        out  1     instruction fetch request
//  mem_addr       out  PC_W  fetch address (= pc)
//  mem_rdata      in   8     instruction byte: [7:4] opcode, [3:0] operand
//  mem_ready      in   1     mem_rdata valid this cycle
//  rom_opcode     out  4     to decode ROM address input (= ir[7:4])
//  rom_ctrl       in   7     from decode ROM data output (combinational)
//  ctrl_word      out  7     registered control word to datapath
//  ctrl_valid     out  1     ctrl_word/operand valid, held through EXEC
//  operand        out  4     ir[3:0]
//  exec_done      in   1     datapath finished current instruction
//  branch_taken   in   1     sampled with exec_done
//  branch_target  in   PC_W  sampled with exec_done
//  halted         out  1     in HALT state
//  instr_cnt      out  16    retired-instruction count
// BEHAVIOUR
//  Reset (async assert, sync use): state=IDLE, pc=RESET_PC, ir=0, ctrl_word=0, instr_cnt=0; all strobes 0.
//  States: IDLE, FETCH, DECODE, EXEC, HALT (one-hot or binary, implementer's choice).
//  IDLE: run=1 -> FETCH next cycle; otherwise stay.
//  FETCH: mem_req=1, mem_addr=pc. mem_ready same cycle: ir<=mem_rdata, -> DECODE.
//   Zero-wait memory: mem_ready in the first FETCH cycle is legal (1-cycle fetch).
//   run dropping in FETCH does not abort; fetch completes.
//  DECODE (exactly 1 cycle): rom_opcode=ir[7:4] is stable; ctrl_word<=rom_ctrl.
//   Opcode==HALT_OP -> HALT and pc<=pc+1, else -> EXEC.
//  EXEC: ctrl_valid=1; ctrl_word/operand held constant. Wait any number of cycles for exec_done.
//   exec_done=1: pc<=branch_taken ? branch_target : pc+1; instr_cnt++.
//   Next state: FETCH if run=1, else IDLE.
//   exec_done outside EXEC is ignored.
//  HALT: halted=1, no mem_req. resume=1 -> FETCH if run=1, else IDLE.
//   HALT instruction counts as retired on HALT entry.
//  Latency: fetch-to-ctrl_valid = 2 cycles after mem_ready cycle (DECODE, then EXEC asserts).
//   Minimum instruction time = 3 cycles (FETCH, DECODE, EXEC with exec_done on first EXEC cycle).
//  Wrap-around: pc+1 wraps modulo 2^PC_W; instr_cnt wraps modulo 2^16; no flags.
//  rom_opcode is always driven from ir (never Z/X), including in IDLE/HALT.
//  rom_ctrl carrying X/Z is sampled only in DECODE; no other dependency.
//  rst_n low mid-instruction: immediate return to reset values; pending mem access abandoned (mem_req drops asynchronously).
// STRUCTURE
//  Package mica_pkg: seq_state_t enum, OPC_W=4, CTRL_W=7, INSTR_W=8, HALT_OP default.
//  Single module, no sub-modules. Decode ROM stays external, connected at core top via rom_opcode/rom_ctrl.
// TESTING
//  Reset then run=1, 0-wait mem, byte 8'h2A at 0, exec_done on first EXEC: ctrl_valid 1 cycle at cycle 3, operand=4'hA, pc=1.
//  Memory returns mem_ready after 4 wait cycles: mem_req/mem_addr held 5 cycles; ir captured only on the ready cycle.
//  EXEC, branch_taken=1, branch_target=8'h40 with exec_done: next mem_addr=8'h40; instr_cnt+1.
//  pc=8'hFF, no branch: next fetch at 8'h00.
//  Byte 8'hF0 (HALT_OP): no ctrl_valid, halted=1, pc advanced. resume with run=1 -> FETCH next cycle.
//  rst_n pulsed low during EXEC with ctrl_valid=1: outputs zero immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mica_pkg.sv
// Shared types and widths for the Mica2 fetch/decode/execute sequencer.
package mica_pkg;

  localparam int OPC_W   = 4;
  localparam int CTRL_W  = 7;
  localparam int INSTR_W = 8;

  localparam logic [OPC_W-1:0] HALT_OP_DEF = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } seq_state_t;

endpackage

// File: rtl/mica_seq.sv
// Multi-cycle sequencer: fetches an instruction byte, registers the external
// decode ROM's control word, and holds it valid until the datapath completes.
module mica_seq
  import mica_pkg::*;
#(
  parameter int               PC_W     = 8,
  parameter logic [OPC_W-1:0] HALT_OP  = HALT_OP_DEF,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               resume,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic [OPC_W-1:0]   rom_opcode,
  input  logic [CTRL_W-1:0]  rom_ctrl,
  output logic [CTRL_W-1:0]  ctrl_word,
  output logic               ctrl_valid,
  output logic [3:0]         operand,
  input  logic               exec_done,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               halted,
  output logic [15:0]        instr_cnt
);

  seq_state_t          state_reg, state_next;
  logic [PC_W-1:0]     pc_reg, pc_next;
  logic [INSTR_W-1:0]  ir_reg, ir_next;
  logic [CTRL_W-1:0]   ctrl_reg, ctrl_next;
  logic [15:0]         cnt_reg, cnt_next;

  logic [PC_W-1:0]     pc_inc;
  assign pc_inc = pc_reg + PC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      ctrl_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      ctrl_reg  <= ctrl_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    ctrl_next  = ctrl_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready) begin
          ir_next    = mem_rdata;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // rom_ctrl is only trusted here, while rom_opcode has been stable a full cycle
        ctrl_next = rom_ctrl;
        if (ir_reg[7:4] == HALT_OP) begin
          pc_next    = pc_inc;
          cnt_next   = cnt_reg + 16'd1;
          state_next = ST_HALT;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          pc_next    = branch_taken ? branch_target : pc_inc;
          cnt_next   = cnt_reg + 16'd1;
          state_next = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALT: begin
        if (resume) state_next = run ? ST_FETCH : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so reset drops them at once.
  assign mem_req    = (state_reg == ST_FETCH);
  assign mem_addr   = pc_reg;
  assign rom_opcode = ir_reg[7:4];
  assign operand    = ir_reg[3:0];
  assign ctrl_word  = ctrl_reg;
  assign ctrl_valid = (state_reg == ST_EXEC);
  assign halted     = (state_reg == ST_HALT);
  assign instr_cnt  = cnt_reg;

endmodule

// File: tb/tb_mica_seq.sv
// Randomized bench for mica_seq against an instruction-level reference model.
module tb_mica_seq;
  import mica_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, run, resume, mem_req, mem_ready;
  logic [7:0]  mem_addr, mem_rdata, branch_target;
  logic [3:0]  rom_opcode, operand;
  logic [6:0]  rom_ctrl, ctrl_word;
  logic        ctrl_valid, exec_done, branch_taken, halted;
  logic [15:0] instr_cnt;

  logic [7:0]  mem [256];
  int          m_pc, m_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  // Stand-in decode ROM: any fixed opcode->control mapping will do.
  function automatic logic [6:0] rom_f(input logic [3:0] op);
    return {op[2:0] ^ 3'b101, ~op};
  endfunction

  assign rom_ctrl = rom_f(rom_opcode);

  mica_seq dut (
    .clk(clk), .rst_n(rst_n), .run(run), .resume(resume),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rom_opcode(rom_opcode), .rom_ctrl(rom_ctrl), .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid),
    .operand(operand), .exec_done(exec_done), .branch_taken(branch_taken),
    .branch_target(branch_target), .halted(halted), .instr_cnt(instr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered with the DUT in FETCH; returns with the DUT in FETCH again.
  task automatic run_instr(input int wait_n, input int exec_wait, input bit br,
                           input int tgt, input bit run_after, input bit res_run);
    logic [7:0] b;
    int         start_pc;
    b = mem[m_pc];
    start_pc = m_pc;
    check("fetch_req", 32'(mem_req), 1);
    check("fetch_addr", 32'(mem_addr), m_pc);
    check("fetch_no_valid", 32'(ctrl_valid), 0);
    for (int w = 0; w < wait_n; w++) begin
      mem_ready = 1'b0;
      mem_rdata = 8'($urandom);
      exec_done = 1'($urandom);
      branch_taken = 1'b1;
      run = 1'($urandom);
      tick();
      check("wait_req", 32'(mem_req), 1);
      check("wait_addr", 32'(mem_addr), m_pc);
    end
    mem_ready = 1'b1;
    mem_rdata = b;
    exec_done = 1'($urandom);
    tick();
    mem_ready = 1'b0;
    mem_rdata = 8'($urandom);
    exec_done = 1'($urandom);
    check("dec_valid", 32'(ctrl_valid), 0);
    check("dec_req", 32'(mem_req), 0);
    check("dec_opcode", 32'(rom_opcode), 32'(b[7:4]));
    check("dec_operand", 32'(operand), 32'(b[3:0]));
    if (b[7:4] == 4'hF) begin
      tick();
      exec_done = 1'b0;
      m_pc  = (m_pc + 1) & 255;
      m_cnt = (m_cnt + 1) & 16'hFFFF;
      check("halt_flag", 32'(halted), 1);
      check("halt_valid", 32'(ctrl_valid), 0);
      check("halt_req", 32'(mem_req), 0);
      check("halt_pc", 32'(mem_addr), m_pc);
      check("halt_cnt", 32'(instr_cnt), m_cnt);
      resume = 1'b0;
      run = 1'($urandom);
      tick();
      check("halt_hold", 32'(halted), 1);
      resume = 1'b1;
      run = res_run;
      tick();
      resume = 1'b0;
      check("resume_unhalt", 32'(halted), 0);
      if (!res_run) begin
        check("resume_idle_req", 32'(mem_req), 0);
        run = 1'b1;
        tick();
      end
      $display("instr pc=%02h byte=%02h HALT waits=%0d resume_run=%0d -> pc=%02h cnt=%0d",
               start_pc, b, wait_n, res_run, m_pc, m_cnt);
    end else begin
      exec_done = 1'b0;
      tick();
      check("exec_valid", 32'(ctrl_valid), 1);
      check("exec_ctrl", 32'(ctrl_word), 32'(rom_f(b[7:4])));
      check("exec_operand", 32'(operand), 32'(b[3:0]));
      check("exec_halted", 32'(halted), 0);
      for (int e = 0; e < exec_wait; e++) begin
        run = 1'($urandom);
        tick();
        check("exec_hold_valid", 32'(ctrl_valid), 1);
        check("exec_hold_ctrl", 32'(ctrl_word), 32'(rom_f(b[7:4])));
      end
      exec_done     = 1'b1;
      branch_taken  = br;
      branch_target = 8'(tgt);
      run           = run_after;
      tick();
      exec_done     = 1'b0;
      branch_taken  = 1'($urandom);
      branch_target = 8'($urandom);
      m_pc  = br ? (tgt & 255) : ((m_pc + 1) & 255);
      m_cnt = (m_cnt + 1) & 16'hFFFF;
      check("retire_cnt", 32'(instr_cnt), m_cnt);
      check("retire_pc", 32'(mem_addr), m_pc);
      check("retire_valid", 32'(ctrl_valid), 0);
      check("retire_req", 32'(mem_req), 32'(run_after));
      if (!run_after) begin
        run = 1'b1;
        tick();
      end
      $display("instr pc=%02h byte=%02h waits=%0d exec=%0d br=%0d tgt=%02h run=%0d -> pc=%02h cnt=%0d",
               start_pc, b, wait_n, exec_wait, br, tgt & 255, run_after, m_pc, m_cnt);
    end
    run = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; resume = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    exec_done = 1'b0; branch_taken = 1'b0; branch_target = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h11;
    m_pc = 0;
    m_cnt = 0;
    tick();
    tick();
    check("rst_req", 32'(mem_req), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_ctrl", 32'(ctrl_word), 0);
    check("rst_valid", 32'(ctrl_valid), 0);
    check("rst_opcode", 32'(rom_opcode), 0);
    check("rst_cnt", 32'(instr_cnt), 0);
    check("rst_halted", 32'(halted), 0);
    rst_n = 1'b1;
    tick();
    check("idle_no_run", 32'(mem_req), 0);
    run = 1'b1;
    tick();

    // Directed sequence: basic, wait states + branch, wrap-around, HALT.
    mem[8'h00] = 8'h2A;
    mem[8'h01] = 8'h35;
    mem[8'h40] = 8'h5C;
    mem[8'hFF] = 8'h71;
    mem[8'h80] = 8'hF0;
    mem[8'h81] = 8'h9B;
    run_instr(0, 0, 1'b0, 0, 1'b1, 1'b1);
    run_instr(4, 1, 1'b1, 8'h40, 1'b1, 1'b1);
    run_instr(1, 0, 1'b1, 8'hFF, 1'b0, 1'b1);
    run_instr(0, 2, 1'b0, 0, 1'b1, 1'b1);
    check("wrap_pc", 32'(mem_addr), 0);
    run_instr(0, 0, 1'b1, 8'h80, 1'b1, 1'b1);
    run_instr(0, 0, 1'b0, 0, 1'b1, 1'b1);

    // Reset pulsed while an instruction is executing.
    check("pre_rst_addr", 32'(mem_addr), 8'h81);
    mem_ready = 1'b1;
    mem_rdata = mem[8'h81];
    tick();
    mem_ready = 1'b0;
    tick();
    check("pre_rst_valid", 32'(ctrl_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(ctrl_valid), 0);
    check("arst_ctrl", 32'(ctrl_word), 0);
    check("arst_req", 32'(mem_req), 0);
    check("arst_addr", 32'(mem_addr), 0);
    check("arst_operand", 32'(operand), 0);
    check("arst_cnt", 32'(instr_cnt), 0);
    tick();
    rst_n = 1'b1;
    m_pc = 0;
    m_cnt = 0;
    run = 1'b1;
    tick();
    check("restart_req", 32'(mem_req), 1);
    check("restart_addr", 32'(mem_addr), 0);

    // Randomized instruction stream.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 150; n++) begin
      run_instr($urandom_range(0, 3), $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 255), ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
